// File: rtl/bus_arb_pkg.sv
// Shared types and mode constants for the N-master bus arbiter.
package bus_arb_pkg;

    // Arbiter FSM: IDLE waits for a request, GRANT holds a master, TURN is the one-cycle dead bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int RR_MODE_FIXED = 0;
    localparam int RR_MODE_RR    = 1;

endpackage

// File: rtl/bus_arbiter_n_rr_pick.sv
// Combinational rotating-base priority picker: the first set request at or after base_i wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] rot;
    logic [IW:0]    sum;

    // Rotate the request vector so base_i lands at bit 0, then take the lowest set bit.
    always_comb begin
        req2 = {req_i, req_i};
        rot  = req2 >> base_i;
        sum  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, base_i} + (IW+1)'(i);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        any_o = |rot[N-1:0];
        idx_o = sum[IW-1:0];
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with round-robin or fixed priority, a single split slot and hold-time preemption.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         breq,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           grant_valid,
    input  logic                           split_req,
    input  logic                           split_done,
    output logic [NUM_MASTERS-1:0]         split,
    output logic                           split_err,
    output logic                           preempt
);

    localparam int N        = NUM_MASTERS;
    localparam int IW       = $clog2(NUM_MASTERS);
    // With preemption disabled the counter still runs; it just saturates at 1.
    localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int HW       = $clog2(HOLD_SAT + 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  bgrant_q, bgrant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  split_q, split_d;
    logic [N-1:0]  resume_q, resume_d;
    logic [IW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  elig;
    logic [N-1:0]  res_elig;
    logic [N-1:0]  pick_req;
    logic [IW-1:0] base;
    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          slot_full;
    logic          timeout;
    logic          split_err_c;
    logic          preempt_c;

    // A parked master is invisible to arbitration; a resumed master outranks everyone.
    always_comb begin
        elig      = breq & ~split_q;
        res_elig  = elig & resume_q;
        pick_req  = (|res_elig) ? res_elig : elig;
        slot_full = |split_q;
        if (RR_MODE == RR_MODE_RR) begin
            base = (last_q == IW'(N - 1)) ? '0 : last_q + IW'(1);
        end else begin
            base = '0;
        end
        timeout = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_SAT)) && (|(elig & ~bgrant_q));
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i  (pick_req),
        .base_i (base),
        .gnt_o  (win_oh),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    // Next-state, grant selection, split slot and hold counter.
    always_comb begin
        state_d     = state_q;
        bgrant_d    = bgrant_q;
        owner_d     = owner_q;
        split_d     = split_q;
        resume_d    = resume_q;
        last_d      = last_q;
        hold_d      = hold_q;
        split_err_c = 1'b0;
        preempt_c   = 1'b0;

        if (split_done && slot_full) begin
            resume_d = resume_q | split_q;
            split_d  = '0;
        end

        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (win_any) begin
                    state_d  = ST_GRANT;
                    bgrant_d = win_oh;
                    owner_d  = win_idx;
                    last_d   = win_idx;
                    hold_d   = HW'(1);
                    resume_d = resume_d & ~win_oh;
                end else begin
                    state_d  = ST_IDLE;
                    bgrant_d = '0;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                if (split_req) begin
                    if (!slot_full) begin
                        split_d  = bgrant_q;
                        state_d  = ST_TURN;
                        bgrant_d = '0;
                        hold_d   = '0;
                    end else begin
                        split_err_c = 1'b1;
                    end
                end else if (!(|(breq & bgrant_q))) begin
                    state_d  = ST_TURN;
                    bgrant_d = '0;
                    hold_d   = '0;
                end else if (timeout) begin
                    preempt_c = 1'b1;
                    state_d   = ST_TURN;
                    bgrant_d  = '0;
                    hold_d    = '0;
                end else if (hold_q != HW'(HOLD_SAT)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bgrant_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; last_q starts at the top index so master 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bgrant_q <= '0;
            owner_q  <= '0;
            split_q  <= '0;
            resume_q <= '0;
            last_q   <= IW'(N - 1);
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            bgrant_q <= bgrant_d;
            owner_q  <= owner_d;
            split_q  <= split_d;
            resume_q <= resume_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
        end
    end

    assign bgrant      = bgrant_q;
    assign owner       = owner_q;
    assign grant_valid = |bgrant_q;
    assign split       = split_q;
    assign split_err   = split_err_c & ~rst;
    assign preempt     = preempt_c & ~rst;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench: three arbiter configurations, each scenario a task with inline checks.
module tb_bus_arbiter_n;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: N=2, round-robin, MAX_HOLD=4
    logic [1:0] a_breq, a_bgrant, a_split;
    logic [0:0] a_owner;
    logic       a_gv, a_sreq, a_sdone, a_serr, a_pre;
    // B: N=4, round-robin, preemption disabled
    logic [3:0] b_breq, b_bgrant, b_split;
    logic [1:0] b_owner;
    logic       b_gv, b_sreq, b_sdone, b_serr, b_pre;
    // C: N=2, fixed priority, MAX_HOLD=64
    logic [1:0] c_breq, c_bgrant, c_split;
    logic [0:0] c_owner;
    logic       c_gv, c_sreq, c_sdone, c_serr, c_pre;

    bus_arbiter_n #(.NUM_MASTERS(2), .RR_MODE(1), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .breq(a_breq), .bgrant(a_bgrant), .owner(a_owner),
        .grant_valid(a_gv), .split_req(a_sreq), .split_done(a_sdone), .split(a_split),
        .split_err(a_serr), .preempt(a_pre));

    bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .breq(b_breq), .bgrant(b_bgrant), .owner(b_owner),
        .grant_valid(b_gv), .split_req(b_sreq), .split_done(b_sdone), .split(b_split),
        .split_err(b_serr), .preempt(b_pre));

    bus_arbiter_n #(.NUM_MASTERS(2), .RR_MODE(0), .MAX_HOLD(64)) u_c (
        .clk(clk), .rst(rst), .breq(c_breq), .bgrant(c_bgrant), .owner(c_owner),
        .grant_valid(c_gv), .split_req(c_sreq), .split_done(c_sdone), .split(c_split),
        .split_err(c_serr), .preempt(c_pre));

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_breq = '0; a_sreq = 1'b0; a_sdone = 1'b0;
        b_breq = '0; b_sreq = 1'b0; b_sdone = 1'b0;
        c_breq = '0; c_sreq = 1'b0; c_sdone = 1'b0;
        step(2);
        checks++;
        if ({a_bgrant, a_owner, a_gv, a_split, a_serr, a_pre} !== 8'b0) begin
            errors++; $display("FAIL reset_a got %b want %b", {a_bgrant, a_owner, a_gv, a_split, a_serr, a_pre}, 8'b0);
        end
        checks++;
        if ({b_bgrant, b_owner, b_gv, b_split, b_serr, b_pre} !== 13'b0) begin
            errors++; $display("FAIL reset_b got %b want %b", {b_bgrant, b_owner, b_gv, b_split, b_serr, b_pre}, 13'b0);
        end
        checks++;
        if ({c_bgrant, c_owner, c_gv, c_split, c_serr, c_pre} !== 8'b0) begin
            errors++; $display("FAIL reset_c got %b want %b", {c_bgrant, c_owner, c_gv, c_split, c_serr, c_pre}, 8'b0);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({a_bgrant, a_gv} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset got %b want %b", {a_bgrant, a_gv}, 3'b000);
        end
    endtask

    task automatic test_rr_basic();
        a_breq = 2'b11;
        step(1);
        checks++;
        if ({a_bgrant, a_owner, a_gv} !== 4'b0101) begin
            errors++; $display("FAIL rr_first_grant got %b want %b", {a_bgrant, a_owner, a_gv}, 4'b0101);
        end
        a_breq = 2'b10;
        step(1);
        checks++;
        if ({a_bgrant, a_gv} !== 3'b000) begin
            errors++; $display("FAIL rr_turn got %b want %b", {a_bgrant, a_gv}, 3'b000);
        end
        step(1);
        checks++;
        if ({a_bgrant, a_owner, a_gv} !== 4'b1011) begin
            errors++; $display("FAIL rr_second_grant got %b want %b", {a_bgrant, a_owner, a_gv}, 4'b1011);
        end
        a_breq = 2'b00;
        step(2);
    endtask

    task automatic test_preempt();
        a_breq = 2'b11;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            checks++;
            if ({a_bgrant, a_pre} !== {2'b01, (c == 4)}) begin
                errors++; $display("FAIL preempt_cycle%0d got %b want %b", c, {a_bgrant, a_pre}, {2'b01, (c == 4)});
            end
        end
        step(1);
        checks++;
        if ({a_bgrant, a_pre} !== 3'b000) begin
            errors++; $display("FAIL preempt_turn got %b want %b", {a_bgrant, a_pre}, 3'b000);
        end
        step(1);
        checks++;
        if ({a_bgrant, a_owner} !== 3'b101) begin
            errors++; $display("FAIL preempt_next_owner got %b want %b", {a_bgrant, a_owner}, 3'b101);
        end
        a_breq = 2'b00;
        step(2);
        a_breq = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            checks++;
            if ({a_bgrant, a_pre} !== 3'b010) begin
                errors++; $display("FAIL no_competitor_cycle%0d got %b want %b", c, {a_bgrant, a_pre}, 3'b010);
            end
        end
    endtask

    task automatic test_split_reset();
        a_sreq = 1'b1;
        #1;
        checks++;
        if (a_serr !== 1'b0) begin
            errors++; $display("FAIL a_split_accept_err got %b want %b", a_serr, 1'b0);
        end
        step(1);
        a_sreq = 1'b0;
        checks++;
        if ({a_split, a_bgrant} !== 4'b0100) begin
            errors++; $display("FAIL a_parked got %b want %b", {a_split, a_bgrant}, 4'b0100);
        end
        step(1);
        checks++;
        if ({a_split, a_bgrant} !== 4'b0100) begin
            errors++; $display("FAIL a_parked_ignored got %b want %b", {a_split, a_bgrant}, 4'b0100);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if ({a_bgrant, a_owner, a_gv, a_split, a_serr, a_pre} !== 8'b0) begin
            errors++; $display("FAIL reset_mid_split got %b want %b", {a_bgrant, a_owner, a_gv, a_split, a_serr, a_pre}, 8'b0);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({a_bgrant, a_gv, a_split} !== 5'b01100) begin
            errors++; $display("FAIL grant_after_reset got %b want %b", {a_bgrant, a_gv, a_split}, 5'b01100);
        end
        a_breq = 2'b00;
        step(2);
    endtask

    task automatic test_rr4_order();
        b_breq = 4'b1111;
        step(1);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if ({b_bgrant, b_owner} !== {4'(1 << (k % 4)), 2'(k % 4)}) begin
                    errors++; $display("FAIL rr4_turn%0d_cycle%0d got %b want %b", k, c, {b_bgrant, b_owner}, {4'(1 << (k % 4)), 2'(k % 4)});
                end
                if (c < 2) step(1);
            end
            b_breq[k % 4] = 1'b0;
            step(1);
            checks++;
            if (b_bgrant !== 4'b0000) begin
                errors++; $display("FAIL rr4_gap%0d got %b want %b", k, b_bgrant, 4'b0000);
            end
            b_breq[k % 4] = 1'b1;
            step(1);
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if ({b_bgrant, b_pre} !== 5'b00100) begin
                errors++; $display("FAIL rr4_no_timeout%0d got %b want %b", c, {b_bgrant, b_pre}, 5'b00100);
            end
        end
        b_breq = 4'b0000;
        step(2);
    endtask

    task automatic test_resume_priority();
        b_breq = 4'b0010;
        step(1);
        checks++;
        if (b_bgrant !== 4'b0010) begin
            errors++; $display("FAIL res_grant1 got %b want %b", b_bgrant, 4'b0010);
        end
        b_sreq = 1'b1;
        step(1);
        b_sreq = 1'b0;
        checks++;
        if ({b_split, b_bgrant} !== 8'b0010_0000) begin
            errors++; $display("FAIL res_park got %b want %b", {b_split, b_bgrant}, 8'b0010_0000);
        end
        b_breq = 4'b0110;
        step(1);
        checks++;
        if (b_bgrant !== 4'b0100) begin
            errors++; $display("FAIL res_grant2 got %b want %b", b_bgrant, 4'b0100);
        end
        b_sdone = 1'b1;
        step(1);
        b_sdone = 1'b0;
        checks++;
        if ({b_split, b_bgrant} !== 8'b0000_0100) begin
            errors++; $display("FAIL res_unpark got %b want %b", {b_split, b_bgrant}, 8'b0000_0100);
        end
        b_breq = 4'b1010;
        step(2);
        checks++;
        if ({b_bgrant, b_owner} !== 6'b0010_01) begin
            errors++; $display("FAIL res_priority got %b want %b", {b_bgrant, b_owner}, 6'b0010_01);
        end
        b_breq = 4'b0000;
        step(2);
    endtask

    task automatic test_split_fixed();
        c_breq = 2'b11;
        step(1);
        checks++;
        if ({c_bgrant, c_owner} !== 3'b010) begin
            errors++; $display("FAIL fx_grant0 got %b want %b", {c_bgrant, c_owner}, 3'b010);
        end
        c_sreq = 1'b1;
        step(1);
        c_sreq = 1'b0;
        checks++;
        if ({c_split, c_bgrant, c_gv} !== 5'b01000) begin
            errors++; $display("FAIL fx_park got %b want %b", {c_split, c_bgrant, c_gv}, 5'b01000);
        end
        step(1);
        checks++;
        if ({c_split, c_bgrant, c_owner} !== 5'b01101) begin
            errors++; $display("FAIL fx_grant1 got %b want %b", {c_split, c_bgrant, c_owner}, 5'b01101);
        end
        c_sreq = 1'b1;
        #1;
        checks++;
        if (c_serr !== 1'b1) begin
            errors++; $display("FAIL fx_split_err got %b want %b", c_serr, 1'b1);
        end
        step(1);
        c_sreq = 1'b0;
        #1;
        checks++;
        if ({c_split, c_bgrant, c_serr} !== 5'b01100) begin
            errors++; $display("FAIL fx_err_no_change got %b want %b", {c_split, c_bgrant, c_serr}, 5'b01100);
        end
        c_sdone = 1'b1;
        step(1);
        c_sdone = 1'b0;
        checks++;
        if ({c_split, c_bgrant} !== 4'b0010) begin
            errors++; $display("FAIL fx_unpark got %b want %b", {c_split, c_bgrant}, 4'b0010);
        end
        c_breq = 2'b01;
        step(1);
        c_breq = 2'b11;
        step(1);
        checks++;
        if ({c_bgrant, c_owner} !== 3'b010) begin
            errors++; $display("FAIL fx_resume_grant got %b want %b", {c_bgrant, c_owner}, 3'b010);
        end
        c_sdone = 1'b1;
        step(1);
        c_sdone = 1'b0;
        checks++;
        if ({c_split, c_bgrant} !== 4'b0001) begin
            errors++; $display("FAIL fx_done_ignored got %b want %b", {c_split, c_bgrant}, 4'b0001);
        end
        c_breq = 2'b10;
        step(1);
        c_sreq = 1'b1;
        #1;
        checks++;
        if (c_serr !== 1'b0) begin
            errors++; $display("FAIL fx_split_in_turn got %b want %b", c_serr, 1'b0);
        end
        step(1);
        c_sreq = 1'b0;
        checks++;
        if ({c_split, c_bgrant} !== 4'b0010) begin
            errors++; $display("FAIL fx_after_turn got %b want %b", {c_split, c_bgrant}, 4'b0010);
        end
        c_breq = 2'b00;
        step(2);
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_preempt();
        test_split_reset();
        test_rr4_order();
        test_resume_priority();
        test_split_fixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
